// File: rtl/switch_cmd_sequencer.sv
// Turns debounced SW[0]/SW[1] rises into register-file writes and reads, shows read
// data for a fixed hold time, and queues one pending command of each kind while busy.
module switch_cmd_sequencer #(
  parameter int Simulacion     = 0,
  parameter int CLK_HZ         = 10_000_000,
  parameter int HOLD_MS_HW     = 500,
  parameter int HOLD_TICKS_SIM = 4,
  parameter int ADDR_W         = 4,
  parameter int DATA_W         = 8,
  parameter int RD_LATENCY     = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sw0_db,
  input  logic              sw_db_d0,
  input  logic              sw1_db,
  input  logic              sw_db_d1,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic              rf_we,
  output logic              rf_re,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              start_pulse,
  output logic              REGLeer,
  output logic [DATA_W-1:0] disp_data,
  output logic              busy,
  output logic              ovf,
  output logic [2:0]        dbg_state
);

  localparam int HOLD_TICKS = (Simulacion != 0) ? HOLD_TICKS_SIM
                                                : (CLK_HZ / 1000) * HOLD_MS_HW;
  localparam int WAIT_W = $clog2(RD_LATENCY + 1);
  localparam int HOLD_W = $clog2(HOLD_TICKS + 1);

  // dbg_state encoding: IDLE=0, WRITE=1, READ_REQ=2, READ_WAIT=3, HOLD=4
  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WRITE     = 3'd1,
    S_READ_REQ  = 3'd2,
    S_READ_WAIT = 3'd3,
    S_HOLD      = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic                wr_pend_q, wr_pend_d, rd_pend_q, rd_pend_d;
  logic                ovf_q, ovf_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic [ADDR_W-1:0]   rf_addr_q, rf_addr_d;
  logic [DATA_W-1:0]   rf_wdata_q, rf_wdata_d;
  logic [DATA_W-1:0]   disp_q, disp_d;
  logic                rf_we_q, rf_re_q, start_q, regleer_q, busy_q;

  logic wr_edge, rd_edge, can_acc, pend_acc;
  logic acc_wr_pend, acc_wr_edge, acc_rd_pend, acc_rd_edge, acc_wr, acc_rd;
  logic wr_keep, wr_lost, rd_keep, rd_lost;

  always_comb begin
    wr_edge  = sw0_db & ~sw_db_d0;
    rd_edge  = sw1_db & ~sw_db_d1;
    can_acc  = (state_q == S_IDLE) || (state_q == S_HOLD);
    // The last WRITE cycle may launch an already-queued command so a queued
    // read runs back-to-back with the write; fresh edges there still queue.
    pend_acc = can_acc || (state_q == S_WRITE);

    acc_wr_pend = pend_acc & wr_pend_q;
    acc_wr_edge = can_acc & ~wr_pend_q & wr_edge;
    acc_rd_pend = pend_acc & ~wr_pend_q & ~(can_acc & wr_edge) & rd_pend_q;
    acc_rd_edge = can_acc & ~wr_pend_q & ~wr_edge & ~rd_pend_q & rd_edge;
    acc_wr      = acc_wr_pend | acc_wr_edge;
    acc_rd      = acc_rd_pend | acc_rd_edge;

    wr_keep   = wr_pend_q & ~acc_wr_pend;
    wr_lost   = wr_edge & ~acc_wr_edge;
    rd_keep   = rd_pend_q & ~acc_rd_pend;
    rd_lost   = rd_edge & ~acc_rd_edge;
    wr_pend_d = wr_keep | wr_lost;
    rd_pend_d = rd_keep | rd_lost;
    ovf_d     = ovf_q | (wr_keep & wr_lost) | (rd_keep & rd_lost);

    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    hold_cnt_d = hold_cnt_q;
    rf_addr_d  = rf_addr_q;
    rf_wdata_d = rf_wdata_q;
    disp_d     = disp_q;

    if (acc_wr || acc_rd) begin
      state_d    = acc_wr ? S_WRITE : S_READ_REQ;
      rf_addr_d  = addr_in;
      rf_wdata_d = data_in;
    end else begin
      case (state_q)
        S_WRITE:    state_d = S_IDLE;
        S_READ_REQ: begin
          state_d    = S_READ_WAIT;
          wait_cnt_d = WAIT_W'(1);
        end
        S_READ_WAIT: begin
          if (wait_cnt_q == WAIT_W'(RD_LATENCY)) begin
            state_d    = S_HOLD;
            hold_cnt_d = HOLD_W'(1);
            disp_d     = rf_rdata;
          end else begin
            wait_cnt_d = wait_cnt_q + 1'b1;
          end
        end
        S_HOLD: begin
          if (hold_cnt_q == HOLD_W'(HOLD_TICKS)) state_d = S_IDLE;
          else                                   hold_cnt_d = hold_cnt_q + 1'b1;
        end
        default:    state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      wr_pend_q  <= 1'b0;
      rd_pend_q  <= 1'b0;
      ovf_q      <= 1'b0;
      wait_cnt_q <= '0;
      hold_cnt_q <= '0;
      rf_addr_q  <= '0;
      rf_wdata_q <= '0;
      disp_q     <= '0;
      rf_we_q    <= 1'b0;
      rf_re_q    <= 1'b0;
      start_q    <= 1'b0;
      regleer_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_pend_q  <= wr_pend_d;
      rd_pend_q  <= rd_pend_d;
      ovf_q      <= ovf_d;
      wait_cnt_q <= wait_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      rf_addr_q  <= rf_addr_d;
      rf_wdata_q <= rf_wdata_d;
      disp_q     <= disp_d;
      rf_we_q    <= (state_d == S_WRITE);
      rf_re_q    <= (state_d == S_READ_REQ);
      start_q    <= acc_wr | acc_rd;
      regleer_q  <= (state_d == S_HOLD);
      busy_q     <= (state_d == S_WRITE) || (state_d == S_READ_REQ) ||
                    (state_d == S_READ_WAIT);
    end
  end

  assign rf_we       = rf_we_q;
  assign rf_re       = rf_re_q;
  assign rf_addr     = rf_addr_q;
  assign rf_wdata    = rf_wdata_q;
  assign start_pulse = start_q;
  assign REGLeer     = regleer_q;
  assign disp_data   = disp_q;
  assign busy        = busy_q;
  assign ovf         = ovf_q;
  assign dbg_state   = state_q;

endmodule
